lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
Load/store sequencer between the MEM pipeline stage and the byte-wide dual-port data RAM. It accepts one 32-bit load or store request (byte/half/word, signed or unsigned), splits it into byte accesses issued two at a time on RAM ports A and B, and reassembles and extends load data. It returns one response pulse per request. Misaligned addresses are legal, and addresses wrap modulo 2^ADDR_W.

Parameters:
ADDR_W, 15, byte-address width; matches RAM depth of 2^ADDR_W bytes.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (handled as word).
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
req_addr  in  ADDR_W  byte address of the lowest byte.
req_wdata  in  32  store data; byte k = req_wdata[8k+7:8k].
rsp_valid  out  1  one-cycle completion pulse (loads and stores).
rsp_rdata  out  32  extended load data; valid with rsp_valid for loads.
ram_addr_a / ram_addr_b  out  ADDR_W  RAM port addresses.
ram_wdata_a / ram_wdata_b  out  8  RAM write data.
ram_we_a / ram_we_b  out  1  RAM write enables.
ram_rdata_a / ram_rdata_b  in  8  RAM read data, registered in the RAM (valid one cycle after address).

Behaviour:
- Reset (rst_n low, async): state=IDLE, request registers=0, rsp_rdata=0, ram_addr_*=0, ram_wdata_*=0. rsp_valid=0, ram_we_*=0 and req_ready=0 while rst_n is low.
- FSM states: IDLE, ISSUE0, ISSUE1, WAIT, RESP.
- req_ready=1 in IDLE and RESP. Acceptance latches we/size/unsigned/addr/wdata and moves to ISSUE0.
- ISSUE0: port A addr=A, wdata=byte0; port B addr=A+1, wdata=byte1.
  - Store: we_a=1; we_b=1 for half or word.
  - Next state: ISSUE1 if word, else RESP for a store, else WAIT for a load.
- ISSUE1 (word only): port A addr=A+2, wdata=byte2; port B addr=A+3, wdata=byte3; we_a=we_b=req_we.
  - Load: capture ram_rdata_a/b into bytes 0/1.
  - Next state: WAIT for a load, RESP for a store.
- WAIT (loads only): capture ram_rdata_a/b into the bytes issued in the previous state (0/1 or 2/3), then go to RESP.
- RESP: rsp_valid=1 and rsp_rdata stable. Next state is ISSUE0 if a new request is accepted this cycle, else IDLE.
- Latency, counted from the accept cycle N: load byte/half RESP at N+3, load word at N+4, store byte/half at N+2, store word at N+3. Back-to-back throughput loses no cycle beyond RESP.
- Outside ISSUE states: ram_we_*=0 and addresses/wdata hold their last value.
- Address arithmetic: A+k computed modulo 2^ADDR_W, so 0x7FFF+1 = 0x0000.
- Ports A and B never carry the same address within a cycle, so no RAM write collision is possible.
- Load extension:
  - byte: bits[31:8] = unsigned ? 0 : byte0[7].
  - half: bits[31:16] = unsigned ? 0 : byte1[7].
  - word: {b3,b2,b1,b0} (little-endian).
- Stores: rsp_rdata holds its previous value; rsp_valid still pulses.
- Reset asserted mid-operation: writes committed at earlier edges stay in the RAM, with no rollback (e.g. bytes 0/1 of a word store are kept). No rsp_valid is produced for the aborted request.
- req_valid while not ready: ignored. The requester holds it until accepted.

Test Plan:
- Preload 0x0100..0x0103 = 11 82 33 C4. Load word 0x0100 -> rsp_valid exactly at N+4, rsp_rdata=0xC4338211, ram_we_* never high.
- Load byte 0x0101 signed -> 0xFFFFFF82 at N+3; unsigned -> 0x00000082. Load half 0x0102 signed -> 0xFFFFC433; half 0x0101 unsigned (misaligned) -> 0x00003382.
- Store word 0x7FFE, data 0xDEADBEEF -> ISSUE0 writes 7FFE=EF, 7FFF=BE; ISSUE1 writes 0000=AD, 0001=DE; rsp_valid at N+3. A following load word 0x7FFE returns 0xDEADBEEF.
- Store byte 0x0200 data 0x000000A5 -> only we_a pulses, one cycle; rsp_valid at N+2. Store half 0x0201 data 0x1234 -> 0201=34, 0202=12.
- req_valid held continuously with alternating load word/store byte -> each new accept happens in the RESP cycle of the previous request; no idle cycles between requests; responses stay in order.
- Word store to 0x0300 data 0xAABBCCDD, rst_n pulled low during ISSUE1 -> ram_we_* drops immediately; 0300=DD, 0301=CC; 0302/0303 unchanged; no rsp_valid. After release, req_ready=1 and state=IDLE.

Source files
------------

// File: rtl/lsu_byte_sequencer.sv
// Splits MEM-stage load/store requests into paired byte accesses on a dual-port byte RAM and reassembles load data.
// Latency from accept cycle N: load b/h rsp at N+3, load word N+4, store b/h N+2, store word N+3.
// Backpressure: req_ready only in IDLE and RESP, so at most one request in flight; a new accept in RESP costs no bubble.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_wdata_a,
  output logic [7:0]        ram_wdata_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [7:0]        ram_rdata_a,
  input  logic [7:0]        ram_rdata_b
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_hi_q, wdata_hi_d;   // bytes 2/3; bytes 0/1 go straight to the port registers at accept
  logic [7:0]        rd_b0_q, rd_b0_d;
  logic [7:0]        rd_b1_q, rd_b1_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] ram_addr_a_q, ram_addr_a_d;
  logic [ADDR_W-1:0] ram_addr_b_q, ram_addr_b_d;
  logic [7:0]        ram_wdata_a_q, ram_wdata_a_d;
  logic [7:0]        ram_wdata_b_q, ram_wdata_b_d;
  logic              ram_we_a_q, ram_we_a_d;
  logic              ram_we_b_q, ram_we_b_d;
  logic              accept;

  // Ready is decoded from state but forced low while reset is held.
  assign req_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign accept    = req_valid && req_ready;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_addr_a  = ram_addr_a_q;
  assign ram_addr_b  = ram_addr_b_q;
  assign ram_wdata_a = ram_wdata_a_q;
  assign ram_wdata_b = ram_wdata_b_q;
  assign ram_we_a    = ram_we_a_q;
  assign ram_we_b    = ram_we_b_q;

  // Next-state and next-output logic; RAM port values are loaded one edge ahead of the ISSUE state that drives them.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_d        = addr_q;
    wdata_hi_d    = wdata_hi_q;
    rd_b0_d       = rd_b0_q;
    rd_b1_d       = rd_b1_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_valid_d   = 1'b0;
    ram_addr_a_d  = ram_addr_a_q;
    ram_addr_b_d  = ram_addr_b_q;
    ram_wdata_a_d = ram_wdata_a_q;
    ram_wdata_b_d = ram_wdata_b_q;
    ram_we_a_d    = 1'b0;
    ram_we_b_d    = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d       = S_ISSUE0;
          we_d          = req_we;
          size_d        = req_size;
          uns_d         = req_unsigned;
          addr_d        = req_addr;
          wdata_hi_d    = req_wdata[31:16];
          ram_addr_a_d  = req_addr;
          ram_addr_b_d  = req_addr + ADDR_W'(1);
          ram_wdata_a_d = req_wdata[7:0];
          ram_wdata_b_d = req_wdata[15:8];
          ram_we_a_d    = req_we;
          ram_we_b_d    = req_we && (req_size != 2'b00);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE0: begin
        // size 10 and reserved 11 are both treated as word
        if (size_q[1]) begin
          state_d       = S_ISSUE1;
          ram_addr_a_d  = addr_q + ADDR_W'(2);
          ram_addr_b_d  = addr_q + ADDR_W'(3);
          ram_wdata_a_d = wdata_hi_q[7:0];
          ram_wdata_b_d = wdata_hi_q[15:8];
          ram_we_a_d    = we_q;
          ram_we_b_d    = we_q;
        end else if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_ISSUE1: begin
        if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          rd_b0_d = ram_rdata_a;
          rd_b1_d = ram_rdata_b;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // RAM now returns the pair issued last: bytes 0/1 for byte/half, bytes 2/3 for word
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        case (size_q)
          2'b00:   rsp_rdata_d = {{24{~uns_q & ram_rdata_a[7]}}, ram_rdata_a};
          2'b01:   rsp_rdata_d = {{16{~uns_q & ram_rdata_b[7]}}, ram_rdata_b, ram_rdata_a};
          default: rsp_rdata_d = {ram_rdata_b, ram_rdata_a, rd_b1_q, rd_b0_q};
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops write enables and the response pulse immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      addr_q        <= '0;
      wdata_hi_q    <= 16'h0;
      rd_b0_q       <= 8'h0;
      rd_b1_q       <= 8'h0;
      rsp_rdata_q   <= 32'h0;
      rsp_valid_q   <= 1'b0;
      ram_addr_a_q  <= '0;
      ram_addr_b_q  <= '0;
      ram_wdata_a_q <= 8'h0;
      ram_wdata_b_q <= 8'h0;
      ram_we_a_q    <= 1'b0;
      ram_we_b_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_q        <= addr_d;
      wdata_hi_q    <= wdata_hi_d;
      rd_b0_q       <= rd_b0_d;
      rd_b1_q       <= rd_b1_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_valid_q   <= rsp_valid_d;
      ram_addr_a_q  <= ram_addr_a_d;
      ram_addr_b_q  <= ram_addr_b_d;
      ram_wdata_a_q <= ram_wdata_a_d;
      ram_wdata_b_q <= ram_wdata_b_d;
      ram_we_a_q    <= ram_we_a_d;
      ram_we_b_q    <= ram_we_b_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a registered-read dual-port byte RAM model.
// Each scenario task drives requests, times the response pulse in cycles after accept and checks data/RAM contents.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_byte_sequencer;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [7:0]    ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
  logic          ram_we_a, ram_we_b;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_byte_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
  );

  // Byte RAM model: registered read, writes on the edge, plus a preload port.
  always @(posedge clk) begin
    if (pre_we)   mem[pre_addr]   <= pre_dat;
    if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
  end

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request; lat = cycles from accept cycle to rsp_valid (-1 if none).
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output int nwa, output int nwb);
    int t;
    lat = -1; rd = 'x; nwa = 0; nwb = 0;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (ram_we_a) nwa++;
      if (ram_we_b) nwb++;
      if (rsp_valid) begin
        lat = k;
        rd  = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if ({ram_we_a, ram_we_b} !== 2'b00) begin bad++; $display("FAIL reset_ram_we: got %b want 00", {ram_we_a, ram_we_b}); end
    total++; if ({ram_addr_a, ram_addr_b} !== 30'h0) begin bad++; $display("FAIL reset_ram_addr: got %h/%h want 0/0", ram_addr_a, ram_addr_b); end
    total++; if ({ram_wdata_a, ram_wdata_b} !== 16'h0) begin bad++; $display("FAIL reset_ram_wdata: got %h/%h want 0/0", ram_wdata_a, ram_wdata_b); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    // RAM contents loaded while the DUT is held in reset
    preload(15'h0100, 8'h11); preload(15'h0101, 8'h82); preload(15'h0102, 8'h33); preload(15'h0103, 8'hC4);
    preload(15'h0200, 8'h00); preload(15'h0201, 8'h00); preload(15'h0202, 8'h00); preload(15'h0203, 8'h00);
    preload(15'h0300, 8'h55); preload(15'h0301, 8'h55); preload(15'h0302, 8'h55); preload(15'h0303, 8'h55);
    preload(15'h0400, 8'h01); preload(15'h0401, 8'h02); preload(15'h0402, 8'h03); preload(15'h0403, 8'h04);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    int lat, nwa, nwb;
    logic [31:0] rd;
    run_req(1'b0, 2'b10, 1'b0, 15'h0100, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 4) begin bad++; $display("FAIL ld_word_lat: got %0d want 4", lat); end
    total++; if (rd !== 32'hC4338211) begin bad++; $display("FAIL ld_word_data: got %h want C4338211", rd); end
    total++; if (nwa + nwb !== 0) begin bad++; $display("FAIL ld_word_we: got %0d write cycles want 0", nwa + nwb); end
    run_req(1'b0, 2'b00, 1'b0, 15'h0101, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 3) begin bad++; $display("FAIL ld_byte_lat: got %0d want 3", lat); end
    total++; if (rd !== 32'hFFFFFF82) begin bad++; $display("FAIL ld_byte_signed: got %h want FFFFFF82", rd); end
    run_req(1'b0, 2'b00, 1'b1, 15'h0101, 32'h0, lat, rd, nwa, nwb);
    total++; if (rd !== 32'h00000082) begin bad++; $display("FAIL ld_byte_unsigned: got %h want 00000082", rd); end
    run_req(1'b0, 2'b00, 1'b0, 15'h0100, 32'h0, lat, rd, nwa, nwb);
    total++; if (rd !== 32'h00000011) begin bad++; $display("FAIL ld_byte_signed_pos: got %h want 00000011", rd); end
    run_req(1'b0, 2'b01, 1'b0, 15'h0102, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 3) begin bad++; $display("FAIL ld_half_lat: got %0d want 3", lat); end
    total++; if (rd !== 32'hFFFFC433) begin bad++; $display("FAIL ld_half_signed: got %h want FFFFC433", rd); end
    run_req(1'b0, 2'b01, 1'b1, 15'h0101, 32'h0, lat, rd, nwa, nwb);
    total++; if (rd !== 32'h00003382) begin bad++; $display("FAIL ld_half_misaligned: got %h want 00003382", rd); end
    run_req(1'b0, 2'b11, 1'b0, 15'h0100, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 4 || rd !== 32'hC4338211) begin bad++; $display("FAIL ld_reserved_size: got lat %0d data %h want 4 C4338211", lat, rd); end
  endtask

  task automatic test_store_wrap();
    int lat, nwa, nwb;
    logic [31:0] rd;
    run_req(1'b1, 2'b10, 1'b0, 15'h7FFE, 32'hDEADBEEF, lat, rd, nwa, nwb);
    total++; if (lat !== 3) begin bad++; $display("FAIL st_word_lat: got %0d want 3", lat); end
    total++; if (nwa !== 2 || nwb !== 2) begin bad++; $display("FAIL st_word_we: got %0d/%0d want 2/2", nwa, nwb); end
    total++; if ({mem[15'h7FFE], mem[15'h7FFF], mem[15'h0000], mem[15'h0001]} !== 32'hEFBEADDE)
      begin bad++; $display("FAIL st_word_wrap_mem: got %h%h%h%h want EFBEADDE", mem[15'h7FFE], mem[15'h7FFF], mem[15'h0000], mem[15'h0001]); end
    run_req(1'b0, 2'b10, 1'b0, 15'h7FFE, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 4 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_word_wrap: got lat %0d data %h want 4 DEADBEEF", lat, rd); end
  endtask

  task automatic test_store_byte_half();
    int lat, nwa, nwb;
    logic [31:0] rd;
    run_req(1'b1, 2'b00, 1'b0, 15'h0200, 32'h000000A5, lat, rd, nwa, nwb);
    total++; if (lat !== 2) begin bad++; $display("FAIL st_byte_lat: got %0d want 2", lat); end
    total++; if (nwa !== 1 || nwb !== 0) begin bad++; $display("FAIL st_byte_we: got %0d/%0d want 1/0", nwa, nwb); end
    total++; if (mem[15'h0200] !== 8'hA5 || mem[15'h0201] !== 8'h00) begin bad++; $display("FAIL st_byte_mem: got %h %h want A5 00", mem[15'h0200], mem[15'h0201]); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL st_rdata_hold: got %h want DEADBEEF", rd); end
    run_req(1'b1, 2'b01, 1'b0, 15'h0201, 32'h00001234, lat, rd, nwa, nwb);
    total++; if (lat !== 2) begin bad++; $display("FAIL st_half_lat: got %0d want 2", lat); end
    total++; if ({mem[15'h0201], mem[15'h0202], mem[15'h0203]} !== 24'h341200)
      begin bad++; $display("FAIL st_half_mem: got %h %h %h want 34 12 00", mem[15'h0201], mem[15'h0202], mem[15'h0203]); end
  endtask

  task automatic test_back_to_back();
    logic          bwe [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]    bsz [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    logic [AW-1:0] bad_ [4] = '{15'h0100, 15'h0401, 15'h0400, 15'h0402};
    logic [31:0]   bwd [4] = '{32'h0, 32'h5A, 32'h0, 32'h77};
    int            blat [4] = '{4, 2, 4, 2};
    logic [31:0]   bexp [4] = '{32'hC4338211, 32'hC4338211, 32'h04035A01, 32'h04035A01};
    int            acc [4] = '{-1, -1, -1, -1};
    int            rsp [4] = '{-1, -1, -1, -1};
    logic [31:0]   rdat [4];
    int cyc, idx, nr;
    logic took;
    @(negedge clk);
    req_we = bwe[0]; req_size = bsz[0]; req_unsigned = 1'b0; req_addr = bad_[0]; req_wdata = bwd[0];
    req_valid = 1'b1;
    cyc = 0; idx = 0; nr = 0; took = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (rsp_valid && nr < 4) begin rsp[nr] = cyc; rdat[nr] = rsp_rdata; nr++; end
      if (req_valid && req_ready && idx < 4) begin acc[idx] = cyc; took = 1'b1; end
      if (nr == 4) break;
      @(negedge clk);
      cyc++;
      if (took) begin
        took = 1'b0;
        idx++;
        if (idx < 4) begin
          req_we = bwe[idx]; req_size = bsz[idx]; req_addr = bad_[idx]; req_wdata = bwd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    total++; if (nr !== 4) begin bad++; $display("FAIL b2b_rsp_count: got %0d want 4", nr); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp[i] - acc[i] !== blat[i]) begin bad++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, rsp[i] - acc[i], blat[i]); end
      total++; if (rdat[i] !== bexp[i]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rdat[i], bexp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (acc[i+1] !== rsp[i]) begin bad++; $display("FAIL b2b_accept_in_resp[%0d]: got cycle %0d want %0d", i, acc[i+1], rsp[i]); end
    end
    total++; if (mem[15'h0402] !== 8'h77) begin bad++; $display("FAIL b2b_store_mem: got %h want 77", mem[15'h0402]); end
  endtask

  task automatic test_reset_mid_op();
    int nrsp, lat, nwa, nwb;
    logic [31:0] rd;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 15'h0300; req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    total++; if ({ram_we_a, ram_we_b} !== 2'b11) begin bad++; $display("FAIL rst_mid_issue0_we: got %b want 11", {ram_we_a, ram_we_b}); end
    @(negedge clk);
    total++; if (ram_addr_a !== 15'h0302 || ram_we_a !== 1'b1) begin bad++; $display("FAIL rst_mid_issue1: got addr %h we %b want 0302 1", ram_addr_a, ram_we_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({ram_we_a, ram_we_b} !== 2'b00) begin bad++; $display("FAIL rst_mid_we_drop: got %b want 00", {ram_we_a, ram_we_b}); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready_low: got %b want 0", req_ready); end
    nrsp = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after: got %b want 1", req_ready); end
    total++; if (ram_addr_a !== 15'h0) begin bad++; $display("FAIL rst_mid_addr_cleared: got %h want 0", ram_addr_a); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    total++; if (nrsp !== 0) begin bad++; $display("FAIL rst_mid_no_rsp: got %0d pulses want 0", nrsp); end
    total++; if ({mem[15'h0300], mem[15'h0301], mem[15'h0302], mem[15'h0303]} !== 32'hDDCC5555)
      begin bad++; $display("FAIL rst_mid_mem: got %h%h%h%h want DDCC5555", mem[15'h0300], mem[15'h0301], mem[15'h0302], mem[15'h0303]); end
    run_req(1'b0, 2'b10, 1'b0, 15'h0300, 32'h0, lat, rd, nwa, nwb);
    total++; if (lat !== 4 || rd !== 32'h5555CCDD) begin bad++; $display("FAIL rst_mid_reload: got lat %0d data %h want 4 5555CCDD", lat, rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = 8'h0;
    test_reset();
    test_loads();
    test_store_wrap();
    test_store_byte_half();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
